alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes a 16-bit unsigned product using only the shared 16-bit ALU. The ALU provides add, shift-left-by-1, shift-right-by-1 and pass-through with a zero flag. The sequencer owns the working registers, drives the ALU operand buses and opcode each cycle, and captures the ALU result. It sits between the instruction control unit, which uses a Start/Busy/Done handshake, and the ALU.

---
 rtl/alu_mul_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add unsigned multiplier that uses the shared
// ALU for every arithmetic step. It drives the ALU operand buses and opcode,
// captures the ALU result into its working registers, and talks to the
// instruction control unit through a Start/Busy/Done handshake.
module alu_mul_sequencer #(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] OP_RESET = 3'b000,
    parameter logic [2:0] OP_ADD   = 3'b001,
    parameter logic [2:0] OP_MUL2  = 3'b100,
    parameter logic [2:0] OP_DIV2  = 3'b110,
    parameter logic [2:0] OP_PASS  = 3'b011
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] AluBusA,
    output logic [WIDTH-1:0] AluBusB,
    output logic [2:0]       AluOperation,
    input  logic [WIDTH-1:0] AluBusC,
    input  logic             AluFlagZ
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_TEST = 3'b001,
        ST_ADD  = 3'b010,
        ST_SHL  = 3'b011,
        ST_SHR  = 3'b100,
        ST_DONE = 3'b101
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] p_r;       // product accumulator
    logic [WIDTH-1:0] m_r;       // multiplicand, shifted left each round
    logic [WIDTH-1:0] q_r;       // multiplier, shifted right each round
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;

    // Next-state decode: the ALU zero flag on Q (via PASS) ends the loop,
    // so leading zero bits of the multiplier cost no extra rounds.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    next_state_s = ST_TEST;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_TEST: begin
                if (AluFlagZ) begin
                    next_state_s = ST_DONE;
                end else if (q_r[0]) begin
                    next_state_s = ST_ADD;
                end else begin
                    next_state_s = ST_SHL;
                end
            end
            ST_ADD:  next_state_s = ST_SHL;
            ST_SHL:  next_state_s = ST_SHR;
            ST_SHR:  next_state_s = ST_TEST;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // ALU drive: operands and opcode are pure decodes of state and registers.
    always_comb begin
        AluOperation = OP_RESET;
        AluBusA      = {WIDTH{1'b0}};
        AluBusB      = {WIDTH{1'b0}};
        case (state_r)
            ST_TEST: begin
                AluOperation = OP_PASS;
                AluBusA      = q_r;
                AluBusB      = q_r;
            end
            ST_ADD: begin
                AluOperation = OP_ADD;
                AluBusA      = p_r;
                AluBusB      = m_r;
            end
            ST_SHL: begin
                AluOperation = OP_MUL2;
                AluBusA      = m_r;
            end
            ST_SHR: begin
                AluOperation = OP_DIV2;
                AluBusA      = q_r;
            end
            default: begin
                AluOperation = OP_RESET;
                AluBusA      = {WIDTH{1'b0}};
                AluBusB      = {WIDTH{1'b0}};
            end
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Working registers: load on accepted Start, capture ALU result per step.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            p_r      <= {WIDTH{1'b0}};
            m_r      <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        p_r <= {WIDTH{1'b0}};
                        m_r <= OperandA;
                        q_r <= OperandB;
                    end
                end
                ST_TEST: begin
                    if (AluFlagZ) begin
                        result_r <= p_r;
                    end
                end
                ST_ADD:  p_r <= AluBusC;
                ST_SHL:  m_r <= AluBusC;
                ST_SHR:  q_r <= AluBusC;
                default: begin
                    p_r <= p_r;
                end
            endcase
        end
    end

    assign Busy   = busy_r;
    assign Done   = done_r;
    assign Result = result_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU drives the DUT's ALU port;
// results and Done timing are compared against arithmetic reference values.
module tb_alu_mul_sequencer;

    logic        Clock;
    logic        ResetN;
    logic        Start;
    logic [15:0] OperandA;
    logic [15:0] OperandB;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic [15:0] AluBusA;
    logic [15:0] AluBusB;
    logic [2:0]  AluOperation;
    logic [15:0] AluBusC;
    logic        AluFlagZ;

    int checks_cnt;
    int errors_cnt;

    alu_mul_sequencer dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .Start        (Start),
        .OperandA     (OperandA),
        .OperandB     (OperandB),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .AluBusA      (AluBusA),
        .AluBusB      (AluBusB),
        .AluOperation (AluOperation),
        .AluBusC      (AluBusC),
        .AluFlagZ     (AluFlagZ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural shared ALU.
    always_comb begin
        AluBusC  = 16'h0000;
        AluFlagZ = 1'b0;
        case (AluOperation)
            3'b000:  AluBusC = 16'h0000;
            3'b001:  AluBusC = AluBusA + AluBusB;
            3'b100:  AluBusC = AluBusA << 1;
            3'b110:  AluBusC = AluBusA >> 1;
            3'b011:  AluBusC = AluBusB;
            default: AluBusC = 16'h0000;
        endcase
        if (AluOperation == 3'b011) begin
            AluFlagZ = (AluBusA == 16'h0000);
        end else begin
            AluFlagZ = (AluBusC == 16'h0000);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_cnt++;
        if (actual !== expected) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] ref_product(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = {16'h0000, a} * {16'h0000, b};
        return full[15:0];
    endfunction

    // Done cycle after the Start edge: 2 for B = 0, else 3(k+1)+popcount+2.
    function automatic int ref_latency(input logic [15:0] b);
        int k;
        int pc;
        k  = -1;
        pc = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                k = i;
                pc++;
            end
        end
        if (k < 0) return 2;
        return 3 * (k + 1) + pc + 2;
    endfunction

    logic [2:0] exp_ops [9];

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input bit check_ops, input bit intrude, input bit hold);
        int lat;
        int done_cycle;
        int done_cnt;
        int busy_cnt;
        logic [15:0] exp;
        lat        = ref_latency(b);
        exp        = ref_product(a, b);
        done_cycle = 0;
        done_cnt   = 0;
        busy_cnt   = 0;
        @(negedge Clock);
        Start    = 1'b1;
        OperandA = a;
        OperandB = b;
        @(posedge Clock);
        for (int c = 1; c <= 80; c++) begin
            @(negedge Clock);
            if (c == 1 && !hold) begin
                Start    = 1'b0;
                OperandA = 16'($urandom);
                OperandB = 16'($urandom);
            end
            if (intrude && c == 4) begin
                Start    = 1'b1;
                OperandA = 16'h0007;
                OperandB = 16'h0007;
            end
            if (intrude && c == 5) begin
                Start = 1'b0;
            end
            if (Busy) busy_cnt++;
            if (check_ops && c <= 9) check_value("alu_op", {29'd0, AluOperation}, {29'd0, exp_ops[c-1]});
            if (Done) begin
                done_cnt++;
                done_cycle = c;
                break;
            end
        end
        check_value("done_seen", {31'd0, (done_cnt == 1)}, 32'd1);
        check_value("done_cycle", done_cycle, lat);
        check_value("busy_cycles", busy_cnt, lat);
        check_value("result", {16'd0, Result}, {16'd0, exp});
        @(negedge Clock);
        check_value("done_once", {31'd0, Done}, 32'd0);
        check_value("idle_after", {31'd0, Busy}, 32'd0);
        check_value("result_held", {16'd0, Result}, {16'd0, exp});
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_ops = '{3'b011, 3'b001, 3'b100, 3'b110, 3'b011, 3'b001, 3'b100, 3'b110, 3'b011};
        ResetN   = 1'b0;
        Start    = 1'b0;
        OperandA = 16'h0000;
        OperandB = 16'h0000;
        repeat (3) @(negedge Clock);
        check_value("rst_busy", {31'd0, Busy}, 32'd0);
        check_value("rst_done", {31'd0, Done}, 32'd0);
        check_value("rst_result", {16'd0, Result}, 32'd0);
        check_value("rst_op", {29'd0, AluOperation}, 32'd0);
        ResetN = 1'b1;
        @(negedge Clock);

        // Directed cases, 5x3 with op sequence and an ignored Start mid-run.
        run_mul(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
        run_mul(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_mul(16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b0);
        run_mul(16'h8000, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_mul(16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0);
        run_mul(16'h0000, 16'h00A5, 1'b0, 1'b0, 1'b0);

        // Start held through DONE: new operation begins after one IDLE cycle.
        run_mul(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        check_value("hold_restart_busy", {31'd0, Busy}, 32'd1);
        check_value("hold_restart_op", {29'd0, AluOperation}, 32'd3);
        Start = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge Clock);
                if (Done) begin
                    seen = 1;
                    break;
                end
            end
            check_value("hold_second_done", seen, 1);
            check_value("hold_second_result", {16'd0, Result}, 32'h0006);
        end
        @(negedge Clock);

        // Asynchronous reset in the middle of a 5x3 run.
        Start    = 1'b1;
        OperandA = 16'h0005;
        OperandB = 16'h0003;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        #2 ResetN = 1'b0;
        #1;
        check_value("arst_busy", {31'd0, Busy}, 32'd0);
        check_value("arst_done", {31'd0, Done}, 32'd0);
        check_value("arst_result", {16'd0, Result}, 32'd0);
        @(negedge Clock);
        ResetN = 1'b1;
        begin
            int dones;
            dones = 0;
            for (int c = 0; c < 15; c++) begin
                @(negedge Clock);
                if (Done || Busy) dones++;
            end
            check_value("arst_quiet", dones, 0);
        end
        run_mul(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

        // Randomized operands against the arithmetic reference.
        for (int n = 0; n < 30; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_mul(ra, rb, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
